// File: rtl/fir_coeff_loader.sv
// Streams host coefficient beats into a FIR tap register array, one write per beat.
// Optional macro COEFF_SYMMETRIC_EN loads half the taps and mirrors each write.
module fir_coeff_loader #(
  parameter int NUM_TAPS = 71,
  parameter int COEFF_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               s_valid,
  input  logic [COEFF_W-1:0] s_data,
  output logic               s_ready,
  output logic               write_en,
  output logic [6:0]         addr,
  output logic [COEFF_W-1:0] coefficient,
  output logic               busy,
  output logic               done,
  output logic [6:0]         loaded_cnt
);

`ifdef COEFF_SYMMETRIC_EN
  localparam int BEATS = (NUM_TAPS + 1) / 2;
`else
  localparam int BEATS = NUM_TAPS;
`endif
  localparam logic [6:0] LAST_BEAT = 7'(BEATS - 1);
  localparam logic [6:0] BEAT_TOT  = 7'(BEATS);
  localparam logic [6:0] LAST_ADDR = 7'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DONE   = 2'd2
`ifdef COEFF_SYMMETRIC_EN
    ,MIRROR = 2'd3
`endif
  } state_t;

  state_t             state_q, state_d;
  logic               write_en_q, write_en_d;
  logic [6:0]         addr_q, addr_d;
  logic [COEFF_W-1:0] coeff_q, coeff_d;
  logic               done_q, done_d;
  logic [6:0]         cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      write_en_q <= 1'b0;
      addr_q     <= '0;
      coeff_q    <= '0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      write_en_q <= write_en_d;
      addr_q     <= addr_d;
      coeff_q    <= coeff_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    write_en_d = 1'b0;
    addr_d     = addr_q;
    coeff_d    = coeff_q;
    done_d     = done_q;
    cnt_d      = cnt_q;
    // abort overrides everything, including a beat handshaking this cycle
    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = LOAD;
            cnt_d   = '0;
            done_d  = 1'b0;
          end
        end
        LOAD: begin
          if (s_valid) begin
            write_en_d = 1'b1;
            addr_d     = cnt_q;
            coeff_d    = s_data;
            cnt_d      = (cnt_q == BEAT_TOT) ? cnt_q : cnt_q + 7'd1;
            if (cnt_q == LAST_BEAT) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
`ifdef COEFF_SYMMETRIC_EN
            else begin
              state_d = MIRROR;
            end
`endif
          end
        end
`ifdef COEFF_SYMMETRIC_EN
        // addr_q/coeff_q still hold beat k, so the mirror tap is derived from them
        MIRROR: begin
          write_en_d = 1'b1;
          addr_d     = LAST_ADDR - addr_q;
          state_d    = LOAD;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  assign s_ready     = (state_q == LOAD);
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign write_en    = write_en_q;
  assign addr        = addr_q;
  assign coefficient = coeff_q;
  assign done        = done_q;
  assign loaded_cnt  = cnt_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized bench for fir_coeff_loader: session-level reference model feeds a write
// scoreboard; a negedge monitor checks writes and status outputs every cycle.
module tb_fir_coeff_loader;
  localparam int NUM_TAPS = 71;
  localparam int COEFF_W  = 8;
`ifdef COEFF_SYMMETRIC_EN
  localparam int TOTAL = (NUM_TAPS + 1) / 2;
  localparam bit SYM   = 1'b1;
`else
  localparam int TOTAL = NUM_TAPS;
  localparam bit SYM   = 1'b0;
`endif
  localparam int CENTRE = (NUM_TAPS - 1) / 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [COEFF_W-1:0] s_data = '0;
  logic               s_ready, write_en, busy, done;
  logic [6:0]         addr, loaded_cnt;
  logic [COEFF_W-1:0] coefficient;

  fir_coeff_loader #(.NUM_TAPS(NUM_TAPS), .COEFF_W(COEFF_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .write_en(write_en), .addr(addr), .coefficient(coefficient),
    .busy(busy), .done(done), .loaded_cnt(loaded_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int a; int v; } wr_t;
  wr_t exp_q[$];
  int  checks = 0, errors = 0;
  bit  mon_en = 1'b0;

  // reference model: session state as the host sees it
  bit m_active, m_done, m_pend;
  int m_k, m_mir_a, m_mir_v;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_done = 0; m_pend = 0; m_k = 0;
    exp_q.delete();
  endfunction

  function automatic void model(input bit st, input bit ab, input bit v, input int dv);
    wr_t w;
    if (ab) begin
      m_active = 0; m_done = 0; m_pend = 0;
      return;
    end
    if (m_pend) begin
      w.a = m_mir_a; w.v = m_mir_v;
      exp_q.push_back(w);
      m_pend = 0;
      return;
    end
    if (m_active) begin
      if (v) begin
        w.a = m_k; w.v = dv;
        exp_q.push_back(w);
        if (SYM && m_k < CENTRE) begin
          m_pend = 1; m_mir_a = NUM_TAPS - 1 - m_k; m_mir_v = dv;
        end
        m_k++;
        if (m_k == TOTAL) begin m_active = 0; m_done = 1; end
      end
    end else if (st) begin
      m_active = 1; m_k = 0; m_done = 0;
    end
  endfunction

  task automatic step(input bit st, input bit ab, input bit v, input logic [COEFF_W-1:0] d);
    start = st; abort = ab; s_valid = v; s_data = d;
    @(posedge clk);
    if (rst_n) model(st, ab, v, int'($signed(d)));
    #1;
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (mon_en) begin
      chk("s_ready", int'(s_ready), int'(m_active && !m_pend));
      chk("busy", int'(busy), int'(m_active));
      chk("done", int'(done), int'(m_done));
      chk("loaded_cnt", int'(loaded_cnt), m_k);
      if (write_en) begin
        if (exp_q.size() == 0) chk("spurious_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(addr), e.a);
          chk("wr_coeff", int'($signed(coefficient)), e.v);
        end
      end else if (exp_q.size() != 0) begin
        chk("missing_write", 0, 1);
        e = exp_q.pop_front();
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_s_ready"}, int'(s_ready), 0);
    chk({tag, "_write_en"}, int'(write_en), 0);
    chk({tag, "_addr"}, int'(addr), 0);
    chk({tag, "_coeff"}, int'(coefficient), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_loaded_cnt"}, int'(loaded_cnt), 0);
  endtask

  task automatic run_to_end(input int mode);
    for (int i = 0; i < 1000 && m_active; i++) begin
      case (mode)
        0: step(0, 0, 1'b1, SYM ? 8'sd5 : 8'(m_k - 35));
        1: step(0, 0, (i % 2) == 0, 8'($urandom));
        default: step(0, 0, ($urandom % 4) != 0, 8'($urandom));
      endcase
    end
    if (m_active) chk("session_timeout", 1, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) step(0, 0, 0, '0);
    chk_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    step(0, 0, 1, 8'h55);  // valid while idle is ignored

    // back-to-back full load
    step(1, 0, 0, '0);
    run_to_end(0);
    step(0, 0, 0, '0);
    chk("full_cnt", int'(loaded_cnt), TOTAL);
    chk("full_done", int'(done), 1);

    // alternating valid
    step(1, 0, 0, '0);
    run_to_end(1);
    step(0, 0, 0, '0);

    // abort together with beat 10
    step(1, 0, 0, '0);
    for (int i = 0; i < 200 && m_active; i++) begin
      if (m_k == 10 && !m_pend) step(0, 1, 1, 8'($urandom));
      else                      step(0, 0, 1, 8'($urandom));
    end
    step(0, 0, 0, '0);
    chk("abort_cnt", int'(loaded_cnt), 10);
    chk("abort_done", int'(done), 0);
    chk("abort_busy", int'(busy), 0);

    // start mid-load is ignored, then restart from DONE
    step(1, 0, 0, '0);
    repeat (5) step(0, 0, 1, 8'($urandom));
    step(1, 0, 1, 8'($urandom));
    step(1, 0, 0, '0);
    run_to_end(2);
    step(1, 0, 0, '0);
    run_to_end(2);
    step(0, 0, 0, '0);

    // reset after 20 beats
    step(1, 0, 0, '0);
    for (int i = 0; i < 200 && m_k < 20; i++) step(0, 0, 1, 8'($urandom));
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_zero("midreset");
    repeat (2) step(0, 0, 1, 8'($urandom));
    rst_n = 1'b1;
    repeat (10) step(0, 0, 1, 8'($urandom));
    chk("post_reset_we", int'(write_en), 0);

    // random mix
    for (int i = 0; i < 3000; i++)
      step(($urandom % 20) == 0, ($urandom % 60) == 0, ($urandom % 3) != 0, 8'($urandom));

    repeat (4) step(0, 0, 0, '0);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fir_coeff_loader.md
FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 71, number of filter taps (odd, 3..127).
REQ-002 SHALL have parameter COEFF_W, default 8, coefficient width in bits (signed).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a load session.
REQ-006 SHALL have port abort, input, 1, terminates the session immediately.
REQ-007 SHALL have port s_valid, input, 1, host coefficient beat valid.
REQ-008 SHALL have port s_data, input, COEFF_W, host coefficient value.
REQ-009 SHALL have port s_ready, output, 1, loader accepts a beat this cycle.
REQ-010 SHALL have port write_en, output, 1, write strobe to the filter coefficient register array.
REQ-011 SHALL have port addr, output, 7, tap address for the write.
REQ-012 SHALL have port coefficient, output, COEFF_W, signed value written.
REQ-013 SHALL have port busy, output, 1, session in progress.
REQ-014 SHALL have port done, output, 1, all taps written, sticky until the next start.
REQ-015 SHALL have port loaded_cnt, output, 7, number of accepted host beats in the current/last session.

Function
REQ-016 SHALL implement states IDLE, LOAD, MIRROR (only with the macro) and DONE.
REQ-017 IDLE/DONE: s_ready=0, write_en=0, busy=0; start -> LOAD, loaded_cnt cleared, done cleared.
REQ-018 LOAD: s_ready=1, busy=1; a beat is accepted when s_valid and s_ready are both high.
REQ-019 Accepted beat k: exactly one cycle later write_en=1, addr=k, coefficient=s_data (registered outputs, latency 1).
REQ-020 write_en SHALL be a single-cycle pulse per write; addr and coefficient hold their last value while write_en=0.
REQ-021 loaded_cnt SHALL increment on each accepted beat, saturating at the session's beat total.
REQ-022 Without the macro, the beat total is NUM_TAPS; acceptance of beat NUM_TAPS-1 -> DONE, s_ready=0 from the next cycle.
REQ-023 DONE: done=1 in the cycle the last write_en pulse is driven, held until start.
REQ-024 start while busy=1 SHALL be ignored; start in DONE restarts a session at address 0.
REQ-025 abort: next state IDLE, done=0, no write_en generated for a beat accepted in the abort cycle (abort wins).
REQ-026 abort and start in the same cycle: abort wins, state IDLE.
REQ-027 s_valid while s_ready=0 SHALL have no effect; the beat is not consumed.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE with s_ready=0, write_en=0, addr=0, coefficient=0, busy=0, done=0, loaded_cnt=0.
REQ-029 Reset mid-session SHALL discard progress; a fresh start is required, no write pulse is issued after reset release.

Configuration
REQ-030 Macro COEFF_SYMMETRIC_EN SHALL enable symmetric-tap loading; without it, REQ-022 governs.
REQ-031 With COEFF_SYMMETRIC_EN, the beat total is (NUM_TAPS+1)/2 (36 at default).
REQ-032 With COEFF_SYMMETRIC_EN, beat k (k < (NUM_TAPS-1)/2) writes addr k at cycle n+1, then MIRROR writes addr NUM_TAPS-1-k with the same value at cycle n+2; s_ready=0 in MIRROR.
REQ-033 With COEFF_SYMMETRIC_EN, the centre beat k=(NUM_TAPS-1)/2 writes once (no MIRROR) and -> DONE.
REQ-034 With COEFF_SYMMETRIC_EN, abort during MIRROR SHALL suppress the mirror write.

Verification
REQ-035 Reset, start, 71 back-to-back beats of value k-35 -> 71 write pulses, addr 0..70 with coefficient -35..35, done=1 at the last pulse, loaded_cnt=71.
REQ-036 Host s_valid toggled 1/0 each cycle -> writes occur only one cycle after each handshake; no gaps or duplicates in addr.
REQ-037 abort asserted together with beat 10 accepted -> last write addr=9, state IDLE, done=0, loaded_cnt=10.
REQ-038 start pulsed in the middle of LOAD -> ignored; restart from DONE -> first write addr=0.
REQ-039 rst_n low after 20 beats -> all outputs 0 immediately; no write_en after release until start.
REQ-040 COEFF_SYMMETRIC_EN, 36 beats of value 5 -> 71 writes, pairs (0,70),(1,69)...(34,36), single write at 35, s_ready low every other cycle.
